// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [15:0] in_rdata1,
  input  logic [15:0] in_rdata2,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [15:0] alu_result,
  input  logic        wb_wen,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_result,
  output logic        ex_valid,
  output logic [2:0]  ex_op,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [3:0]  ex_rd,
  output logic        ex_wen,
  output logic        ex_is_load,
  output logic        hazard_stall,
  output logic [15:0] bubble_cnt
);

  logic        r_valid;
  logic [2:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_rd;
  logic        r_wen;
  logic        r_is_load;
  logic [15:0] r_bubble_cnt;

  logic [3:0]  w_rs    [2];
  logic [15:0] w_rdata [2];
  logic [15:0] w_fwd   [2];
  logic        w_load_use;
  logic        w_ex_fwd_ok;
  logic [15:0] w_cnt_inc;

  assign w_rs[0]    = in_rs1;
  assign w_rs[1]    = in_rs2;
  assign w_rdata[0] = in_rdata1;
  assign w_rdata[1] = in_rdata2;

  // A load's result isn't known in EX, so only non-load writers forward from EX.
  assign w_ex_fwd_ok = r_valid & r_wen & ~r_is_load;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        w_fwd[gi] = w_rdata[gi];
        if (w_rs[gi] == 4'd0) begin
          w_fwd[gi] = 16'd0;
        end else if (FWD_EN) begin
          if (w_ex_fwd_ok && (r_rd == w_rs[gi])) begin
            w_fwd[gi] = alu_result;
          end else if (wb_wen && (wb_rd == w_rs[gi])) begin
            w_fwd[gi] = wb_result;
          end
        end
      end
    end
  endgenerate

  assign w_load_use = r_valid & r_is_load & r_wen & (r_rd != 4'd0) & in_valid &
                      ((in_rs1 == r_rd) | (~in_use_imm & (in_rs2 == r_rd)));

  assign w_cnt_inc = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_op         <= 3'd0;
      r_a          <= 16'd0;
      r_b          <= 16'd0;
      r_rd         <= 4'd0;
      r_wen        <= 1'b0;
      r_is_load    <= 1'b0;
      r_bubble_cnt <= 16'd0;
    end else if (flush || (!stall && w_load_use)) begin
      r_valid      <= 1'b0;
      r_op         <= 3'd0;
      r_a          <= 16'd0;
      r_b          <= 16'd0;
      r_rd         <= 4'd0;
      r_wen        <= 1'b0;
      r_is_load    <= 1'b0;
      r_bubble_cnt <= w_cnt_inc;
    end else if (stall) begin
      r_valid      <= r_valid;
    end else if (!in_valid) begin
      // Idle bubble: nothing was squashed, so the counter is left alone.
      r_valid      <= 1'b0;
      r_op         <= 3'd0;
      r_a          <= 16'd0;
      r_b          <= 16'd0;
      r_rd         <= 4'd0;
      r_wen        <= 1'b0;
      r_is_load    <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_op         <= in_op;
      r_a          <= w_fwd[0];
      r_b          <= in_use_imm ? in_imm : w_fwd[1];
      r_rd         <= in_rd;
      r_wen        <= in_wen;
      r_is_load    <= in_is_load;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_op        = r_op;
  assign ex_a         = r_a;
  assign ex_b         = r_b;
  assign ex_rd        = r_rd;
  assign ex_wen       = r_wen;
  assign ex_is_load   = r_is_load;
  assign hazard_stall = w_load_use;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, load-use, stall/flush,
// reset override and bubble counter saturation.
module tb_id_ex_stage;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_use_imm, in_wen, in_is_load, wb_wen;
  logic [2:0]  in_op;
  logic [3:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic [15:0] in_rdata1, in_rdata2, in_imm, alu_result, wb_result;

  logic        ex_valid, ex_wen, ex_is_load, hazard_stall;
  logic [2:0]  ex_op;
  logic [15:0] ex_a, ex_b, bubble_cnt;
  logic [3:0]  ex_rd;

  logic        nf_valid, nf_wen, nf_is_load, nf_hazard;
  logic [2:0]  nf_op;
  logic [15:0] nf_a, nf_b, nf_cnt;
  logic [3:0]  nf_rd;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_wen(in_wen), .in_is_load(in_is_load),
    .alu_result(alu_result), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_wen(in_wen), .in_is_load(in_is_load),
    .alu_result(alu_result), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(nf_valid), .ex_op(nf_op), .ex_a(nf_a), .ex_b(nf_b), .ex_rd(nf_rd),
    .ex_wen(nf_wen), .ex_is_load(nf_is_load), .hazard_stall(nf_hazard),
    .bubble_cnt(nf_cnt)
  );

  // Packed view: {valid, op, a, b, rd, wen, is_load}
  logic [41:0] ex_all;
  assign ex_all = {ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wen, ex_is_load};
  localparam logic [41:0] EX_BUBBLE = 42'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [2:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [3:0] rd, input logic [15:0] d1, input logic [15:0] d2,
                             input logic [15:0] imm, input logic use_imm, input logic wen,
                             input logic is_load);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rdata1 = d1; in_rdata2 = d2; in_imm = imm; in_use_imm = use_imm;
    in_wen = wen; in_is_load = is_load;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_wen = 1'b0; wb_rd = 4'd0;
    wb_result = 16'd0; alu_result = 16'd0;
    drive_instr(OP_ADD, 4'd1, 4'd2, 4'd3, 16'd5, 16'd7, 16'd0, 1'b0, 1'b1, 1'b0);
    step(); step();
    rst = 1'b0;
    total_cnt++;
    if (ex_all !== EX_BUBBLE) $display("FAIL reset_fields got=%h exp=%h", ex_all, EX_BUBBLE);
    else pass_cnt++;
    total_cnt++;
    if (bubble_cnt !== 16'd0) $display("FAIL reset_cnt got=%h exp=0000", bubble_cnt);
    else pass_cnt++;
    $display("tx reset: ex=%h cnt=%h", ex_all, bubble_cnt);
  endtask

  task automatic test_add();
    drive_instr(OP_ADD, 4'd1, 4'd2, 4'd3, 16'd5, 16'd7, 16'd0, 1'b0, 1'b1, 1'b0);
    step();
    total_cnt++;
    if (ex_all !== {1'b1, OP_ADD, 16'd5, 16'd7, 4'd3, 1'b1, 1'b0})
      $display("FAIL add_basic got=%h exp=%h", ex_all, {1'b1, OP_ADD, 16'd5, 16'd7, 4'd3, 1'b1, 1'b0});
    else pass_cnt++;
    $display("tx add: ex=%h", ex_all);
  endtask

  task automatic test_forward();
    // EX holds rd=3 writer; both EX and WB target r3, EX must win; rs2=r0 reads zero.
    alu_result = 16'd12; wb_wen = 1'b1; wb_rd = 4'd3; wb_result = 16'd99;
    drive_instr(OP_SUB, 4'd3, 4'd0, 4'd5, 16'd0, 16'h0055, 16'd0, 1'b0, 1'b1, 1'b0);
    step();
    total_cnt++;
    if (ex_a !== 16'd12) $display("FAIL fwd_ex_priority got=%h exp=000c", ex_a);
    else pass_cnt++;
    total_cnt++;
    if (ex_b !== 16'd0) $display("FAIL fwd_r0_zero got=%h exp=0000", ex_b);
    else pass_cnt++;
    $display("tx fwd_ex: a=%h b=%h", ex_a, ex_b);
    // EX now holds rd=5; r3 only matches WB. rs2=7 has no producer.
    alu_result = 16'hDEAD;
    drive_instr(OP_AND, 4'd3, 4'd7, 4'd6, 16'h0777, 16'h1234, 16'd0, 1'b0, 1'b1, 1'b0);
    step();
    total_cnt++;
    if ({ex_a, ex_b} !== {16'd99, 16'h1234})
      $display("FAIL fwd_wb got=%h exp=%h", {ex_a, ex_b}, {16'd99, 16'h1234});
    else pass_cnt++;
    total_cnt++;
    if ({nf_a, nf_b} !== {16'h0777, 16'h1234})
      $display("FAIL nofwd_raw got=%h exp=%h", {nf_a, nf_b}, {16'h0777, 16'h1234});
    else pass_cnt++;
    $display("tx fwd_wb: a=%h b=%h nf_a=%h", ex_a, ex_b, nf_a);
    // Immediate overrides a matching rs2 forward.
    alu_result = 16'h4444;
    drive_instr(OP_ADD, 4'd6, 4'd6, 4'd7, 16'd1, 16'd2, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    step();
    total_cnt++;
    if ({ex_a, ex_b} !== {16'h4444, 16'hBEEF})
      $display("FAIL fwd_imm got=%h exp=%h", {ex_a, ex_b}, {16'h4444, 16'hBEEF});
    else pass_cnt++;
    $display("tx fwd_imm: a=%h b=%h", ex_a, ex_b);
    wb_wen = 1'b0;
  endtask

  task automatic test_load_use();
    drive_instr(OP_ADD, 4'd1, 4'd0, 4'd4, 16'd10, 16'd0, 16'd2, 1'b1, 1'b1, 1'b1);
    step();
    // Load result must not be forwarded from EX even though rd matches.
    alu_result = 16'h7777;
    drive_instr(OP_ADD, 4'd2, 4'd4, 4'd5, 16'h0020, 16'h0030, 16'h0003, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (hazard_stall !== 1'b0) $display("FAIL lu_imm_no_hazard got=%b exp=0", hazard_stall);
    else pass_cnt++;
    in_use_imm = 1'b0;
    #1;
    total_cnt++;
    if (hazard_stall !== 1'b1) $display("FAIL lu_detect got=%b exp=1", hazard_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({ex_all, bubble_cnt} !== {EX_BUBBLE, 16'd1})
      $display("FAIL lu_bubble got=%h exp=%h", {ex_all, bubble_cnt}, {EX_BUBBLE, 16'd1});
    else pass_cnt++;
    total_cnt++;
    if (hazard_stall !== 1'b0) $display("FAIL lu_cleared got=%b exp=0", hazard_stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ex_all !== {1'b1, OP_ADD, 16'h0020, 16'h0030, 4'd5, 1'b1, 1'b0})
      $display("FAIL lu_replay got=%h exp=%h", ex_all, {1'b1, OP_ADD, 16'h0020, 16'h0030, 4'd5, 1'b1, 1'b0});
    else pass_cnt++;
    $display("tx load_use: ex=%h cnt=%h", ex_all, bubble_cnt);
  endtask

  task automatic test_stall();
    logic [41:0] exp_all;
    drive_instr(OP_SUB, 4'd1, 4'd2, 4'd6, 16'h0A0A, 16'h0B0B, 16'd0, 1'b0, 1'b1, 1'b0);
    step();
    exp_all = {1'b1, OP_SUB, 16'h0A0A, 16'h0B0B, 4'd6, 1'b1, 1'b0};
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_instr(OP_AND, 4'd8 + 4'(i), 4'd9, 4'd10 + 4'(i), 16'h1111 * 16'(i + 1),
                  16'h0F0F, 16'd0, 1'b0, 1'b0, 1'b0);
      step();
      total_cnt++;
      if ({ex_all, bubble_cnt} !== {exp_all, 16'd1})
        $display("FAIL stall_hold%0d got=%h exp=%h", i, {ex_all, bubble_cnt}, {exp_all, 16'd1});
      else pass_cnt++;
      $display("tx stall%0d: ex=%h", i, ex_all);
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    total_cnt++;
    if ({ex_all, bubble_cnt} !== {EX_BUBBLE, 16'd2})
      $display("FAIL stall_flush got=%h exp=%h", {ex_all, bubble_cnt}, {EX_BUBBLE, 16'd2});
    else pass_cnt++;
    $display("tx stall_flush: ex=%h cnt=%h", ex_all, bubble_cnt);
  endtask

  task automatic test_invalid_and_flush_lu();
    drive_instr(OP_ADD, 4'd1, 4'd2, 4'd3, 16'd1, 16'd2, 16'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    total_cnt++;
    if ({ex_all, bubble_cnt} !== {EX_BUBBLE, 16'd2})
      $display("FAIL invalid_bubble got=%h exp=%h", {ex_all, bubble_cnt}, {EX_BUBBLE, 16'd2});
    else pass_cnt++;
    drive_instr(OP_ADD, 4'd1, 4'd0, 4'd4, 16'd3, 16'd0, 16'd2, 1'b1, 1'b1, 1'b1);
    step();
    drive_instr(OP_ADD, 4'd4, 4'd0, 4'd5, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total_cnt++;
    if (hazard_stall !== 1'b1) $display("FAIL flush_lu_hazard got=%b exp=1", hazard_stall);
    else pass_cnt++;
    step();
    flush = 1'b0;
    total_cnt++;
    if ({ex_all, bubble_cnt} !== {EX_BUBBLE, 16'd3})
      $display("FAIL flush_lu_once got=%h exp=%h", {ex_all, bubble_cnt}, {EX_BUBBLE, 16'd3});
    else pass_cnt++;
    $display("tx flush_lu: ex=%h cnt=%h", ex_all, bubble_cnt);
  endtask

  task automatic test_reset_mid_hazard();
    drive_instr(OP_ADD, 4'd1, 4'd0, 4'd4, 16'd3, 16'd0, 16'd2, 1'b1, 1'b1, 1'b1);
    step();
    drive_instr(OP_ADD, 4'd4, 4'd0, 4'd5, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    total_cnt++;
    if ({ex_all, bubble_cnt, hazard_stall} !== {EX_BUBBLE, 16'd0, 1'b0})
      $display("FAIL reset_override got=%h exp=%h", {ex_all, bubble_cnt, hazard_stall},
               {EX_BUBBLE, 16'd0, 1'b0});
    else pass_cnt++;
    $display("tx reset_mid: ex=%h cnt=%h hz=%b", ex_all, bubble_cnt, hazard_stall);
  endtask

  task automatic test_saturation();
    flush = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    total_cnt++;
    if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", bubble_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt);
    else pass_cnt++;
    flush = 1'b0;
    $display("tx saturation: cnt=%h", bubble_cnt);
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_stall();
    test_invalid_and_flush_lu();
    test_reset_mid_hazard();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, 1 enables operand forwarding; 0 takes in_rdata1/in_rdata2 unmodified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  downstream hold request; register contents frozen.
REQ-005 flush  input  1  squash; next register contents are a bubble.
REQ-006 in_valid  input  1  decoded instruction present.
REQ-007 in_op  input  3  ALU opcode (ADD, SUB, AND, XOR, SLL, SRL, COM, MUL encoding of define.v).
REQ-008 in_rs1, in_rs2, in_rd  input  4 each  source/destination register indices; r0 reads zero.
REQ-009 in_rdata1, in_rdata2  input  16 each  register-file read data.
REQ-010 in_imm  input  16  immediate; in_use_imm  input  1  selects in_imm as operand b.
REQ-011 in_wen  input  1  instruction writes rd; in_is_load  input  1  instruction is a load.
REQ-012 alu_result  input  16  combinational ALU result of the instruction currently held (EX forward source).
REQ-013 wb_wen  input  1, wb_rd  input  4, wb_result  input  16  write-back forward source.
REQ-014 ex_valid  output  1; ex_op  output  3; ex_a, ex_b  output  16; ex_rd  output  4; ex_wen, ex_is_load  output  1  registered EX-stage fields driving the ALU.
REQ-015 hazard_stall  output  1  combinational load-use stall request to upstream.
REQ-016 bubble_cnt  output  16  count of inserted bubbles.

Function
REQ-017 Latency: fields captured at edge N appear on ex_* from edge N until next update (one-cycle stage).
REQ-018 Update priority per edge: rst > flush > stall > load_use > load.
REQ-019 load_use = ex_valid & ex_is_load & ex_wen & (ex_rd != 0) & in_valid & ((in_rs1 == ex_rd) | (~in_use_imm & in_rs2 == ex_rd)); hazard_stall = load_use, independent of stall/flush.
REQ-020 Bubble (flush, load_use, or in_valid=0): ex_valid=0, ex_wen=0, ex_is_load=0, ex_op=0, ex_a=0, ex_b=0, ex_rd=0.
REQ-021 stall=1 (no rst/flush): all ex_* and bubble_cnt hold.
REQ-022 Load: ex_op<=in_op, ex_rd<=in_rd, ex_wen<=in_wen, ex_is_load<=in_is_load, ex_valid<=1.
REQ-023 Operand fwd(rs, rdata): rs==0 -> 0; else ex_valid & ex_wen & ~ex_is_load & ex_rd==rs -> alu_result; else wb_wen & wb_rd==rs -> wb_result; else rdata; EX source wins over WB.
REQ-024 ex_a <= fwd(in_rs1, in_rdata1); ex_b <= in_use_imm ? in_imm : fwd(in_rs2, in_rdata2).
REQ-025 FWD_EN=0: fwd returns rdata (r0 still zero); load_use detection unchanged.
REQ-026 bubble_cnt increments by 1 on each edge a bubble is captured due to load_use or flush (not in_valid=0); saturates at 16'hFFFF.
REQ-027 flush and load_use same cycle: one bubble, bubble_cnt +1 only.
REQ-028 No combinational path from alu_result/wb_* to any output.

Reset
REQ-029 On rst edge: ex_valid=0, ex_wen=0, ex_is_load=0, ex_op=0, ex_a=0, ex_b=0, ex_rd=0, bubble_cnt=0; rst overrides stall and flush.
REQ-030 rst asserted mid-hazard: next cycle ex_valid=0 so hazard_stall=0.

Verification
REQ-031 ADD r3=r1+r2, rdata1=5, rdata2=7, no hazards -> next cycle ex_valid=1, ex_op=ADD, ex_a=5, ex_b=7, ex_rd=3.
REQ-032 EX holds wen rd=3, alu_result=12, wb_wen rd=3 wb_result=99; next instr rs1=3 rdata1=0 -> ex_a=12 (EX priority); rs2=0 rdata2=0x55 -> ex_b=0.
REQ-033 EX holds load rd=4; in rs2=4, in_use_imm=0 -> hazard_stall=1, next ex_valid=0, bubble_cnt=1; same instr with in_use_imm=1, rs1=2 -> hazard_stall=0.
REQ-034 stall=1 for 3 cycles with changing inputs -> ex_* and bubble_cnt unchanged; flush with stall=1 -> bubble captured.
REQ-035 rst asserted with stall=1 and valid content -> all outputs zero next cycle; bubble_cnt preloaded path at 0xFFFF plus flush -> stays 0xFFFF.
